// File: rtl/uart_rx_parity.sv
// UART receive path: 16x oversampled start/data/parity/stop deframer with error flags.
// Optional parity bit support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_parity #(
  parameter int unsigned data_length = 8
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst_n,
  input  logic                   i_baud_tick,
  input  logic                   i_rxd,
  input  logic                   i_parity_type,
  output logic [data_length-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_parity_err,
  output logic                   o_frame_err,
  output logic                   o_busy
);

  // state  | meaning
  // IDLE   | line idle, watching for a falling edge every clock
  // START  | confirming the start bit at its mid-point (cnt == 7)
  // DATA   | sampling data bits LSB first every 16 ticks
  // PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
  // STOP   | sampling the stop bit, then reporting the frame
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(data_length - 1);

  state_t                 state, state_nxt;
  logic                   rxd_meta, rxd_sync, rxd_prev;
  logic                   fall_edge;
  logic [3:0]             cnt;
  logic [3:0]             bit_idx;
  logic [data_length-1:0] shift_reg;
  logic                   cnt_clr, start_ok, shift_en, stop_en;
  logic                   mid_tick, end_tick;

  assign fall_edge = rxd_prev & ~rxd_sync;
  assign mid_tick  = i_baud_tick && (cnt == 4'd7);
  assign end_tick  = i_baud_tick && (cnt == 4'd15);
  assign o_busy    = (state != ST_IDLE);

  // Synchronizer and edge-detect history all reset to the idle (high) line level.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= i_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
`endif

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (fall_edge) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (mid_tick) begin
          if (rxd_sync) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_clr   = 1'b1;
            start_ok  = 1'b1;
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (end_tick) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (end_tick) begin
          par_en    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (end_tick) begin
          stop_en   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      cnt <= 4'd0;
    end else if (cnt_clr) begin
      cnt <= 4'd0;
    end else if (i_baud_tick) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Shifting in from the top leaves the first received bit in the LSB after data_length shifts.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      bit_idx   <= 4'd0;
      shift_reg <= '0;
    end else begin
      if (start_ok) begin
        bit_idx <= 4'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 4'd1;
      end
      if (shift_en) begin
        shift_reg <= {rxd_sync, shift_reg[data_length-1:1]};
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid <= stop_en;
      if (stop_en) begin
        o_data      <= shift_reg;
        o_frame_err <= ~rxd_sync;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity type is captured at start-bit confirmation so mid-frame changes cannot leak in.
  logic ptype_q;
  logic par_err_q;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      ptype_q      <= 1'b0;
      par_err_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (start_ok) begin
        ptype_q <= i_parity_type;
      end
      if (par_en) begin
        par_err_q <= (^shift_reg) ^ rxd_sync ^ ptype_q;
      end
      if (stop_en) begin
        o_parity_err <= par_err_q;
      end
    end
  end
`else
  logic unused_parity_type;
  assign unused_parity_type = i_parity_type;
  assign o_parity_err       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: table of frames plus hand sequences for
// frame error, false start, back-to-back frames and mid-frame reset.
module tb_uart_rx_parity;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       i_baud_tick;
  logic       i_rxd;
  logic       i_parity_type;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx_parity #(.data_length(8)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_baud_tick  (i_baud_tick),
    .i_rxd        (i_rxd),
    .i_parity_type(i_parity_type),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned cyc;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       ptype;
    logic       pbit;
    logic       flip;
    logic       exp_perr;
  } vec_t;

  rec_t        rec_q[$];
  int unsigned cyc;
  int          checks;
  int          passed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    logic [1:0] div;
    div = 2'd0;
    i_baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = div + 2'd1;
      i_baud_tick = (div == 2'd3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Valid monitor: records each report and checks the strobe lasts one clock.
  initial begin
    logic prev_v;
    rec_t r;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid) begin
        check("valid_one_clock", {31'd0, prev_v}, 32'd0);
        r.d = o_data; r.pe = o_parity_err; r.fe = o_frame_err; r.cyc = cyc;
        rec_q.push_back(r);
      end
      prev_v = o_valid;
    end
  end

  task automatic idle_bits(input int n);
    i_rxd = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    i_rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (flip && i == 2) i_parity_type = ~i_parity_type;
    end
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(sbit);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp_d, input logic exp_pe,
                           input logic exp_fe, output rec_t r);
    check({name, "_count"}, rec_q.size(), 32'd1);
    if (rec_q.size() > 0) r = rec_q.pop_front();
    else r = '0;
    rec_q.delete();
    check({name, "_data"}, {24'd0, r.d}, {24'd0, exp_d});
`ifdef UART_RX_PARITY_EN
    check({name, "_perr"}, {31'd0, r.pe}, {31'd0, exp_pe});
`else
    check({name, "_perr"}, {31'd0, r.pe}, 32'd0);
`endif
    check({name, "_ferr"}, {31'd0, r.fe}, {31'd0, exp_fe});
  endtask

  initial begin
    vec_t vecs[6];
    rec_t r, r1, r2;
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    i_rxd = 1'b1;
    i_parity_type = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hE6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_perr", {31'd0, o_parity_err}, 32'd0);
    check("rst_ferr", {31'd0, o_frame_err}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    for (int v = 0; v < 6; v++) begin
      i_parity_type = vecs[v].ptype;
      send_frame(vecs[v].data, vecs[v].pbit, 1'b1, vecs[v].flip);
      idle_bits(1);
      pop_check($sformatf("vec%0d", v), vecs[v].data, vecs[v].exp_perr, 1'b0, r);
    end

    // Frame error with the line held low afterwards: only one report.
    i_parity_type = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (19 * BIT_CLKS) @(negedge clk);
    pop_check("ferr", 8'h3C, 1'b0, 1'b1, r);
    idle_bits(2);
    check("ferr_no_retrigger", rec_q.size(), 32'd0);
    send_frame(8'h96, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    pop_check("after_ferr", 8'h96, 1'b0, 1'b0, r);

    // False start: 6 ticks low.
    i_rxd = 1'b0;
    repeat (24) @(negedge clk);
    i_rxd = 1'b1;
    repeat (8) @(negedge clk);
    check("false_start_busy_hi", {31'd0, o_busy}, 32'd1);
    idle_bits(2);
    check("false_start_busy_lo", {31'd0, o_busy}, 32'd0);
    check("false_start_no_valid", rec_q.size(), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    pop_check("after_false", 8'h5A, 1'b0, 1'b0, r);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    check("b2b_count", rec_q.size(), 32'd2);
    r1 = '0; r2 = '0;
    if (rec_q.size() > 0) r1 = rec_q.pop_front();
    if (rec_q.size() > 0) r2 = rec_q.pop_front();
    rec_q.delete();
    check("b2b_data0", {24'd0, r1.d}, 32'h00);
    check("b2b_data1", {24'd0, r2.d}, 32'hFF);
    check("b2b_err", {30'd0, r1.pe | r2.pe, r1.fe | r2.fe}, 32'd0);
    check("b2b_gap", r2.cyc - r1.cyc, FRAME_BITS * BIT_CLKS);

    // Reset during data bit 4 of 0x3F.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i_rxd = 1'b1;
    repeat (32) @(negedge clk);
    check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_data", {24'd0, o_data}, 32'd0);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_perr", {31'd0, o_parity_err}, 32'd0);
    check("mid_rst_ferr", {31'd0, o_frame_err}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(12);
    check("mid_rst_no_valid", rec_q.size(), 32'd0);
    check("mid_rst_idle", {31'd0, o_busy}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    pop_check("after_rst", 8'h81, 1'b0, 1'b0, r);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

Serial receive path of the UART 16550 core, the counterpart of the transmit-side parity generator. Oversamples the incoming line at 16x baud, validates the start bit, shifts in `data_length` bits LSB first, checks the parity bit against the programmed even/odd type, and checks the stop bit. Each completed frame is presented to the receive FIFO/register interface as a one-cycle strobe with the data word and error flags.

## Interface
- `data_length`, default 8: number of data bits per frame (5..8).
- `i_sys_clk`, in, 1: system clock; all logic on its rising edge.
- `i_sys_rst_n`, in, 1: reset, synchronous and active-low.
- `i_baud_tick`, in, 1: one-cycle enable at 16x the baud rate, from the divisor block.
- `i_rxd`, in, 1: serial line; idle high; asynchronous to `i_sys_clk`.
- `i_parity_type`, in, 1: 0 selects even parity, 1 selects odd parity.
- `o_data`, out, `data_length`: last received word, LSB = first bit on the line.
- `o_valid`, out, 1: one-cycle strobe; a frame has completed.
- `o_parity_err`, out, 1: parity mismatch for the frame reported by the last `o_valid`.
- `o_frame_err`, out, 1: stop bit sampled low for the frame reported by the last `o_valid`.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- `i_rxd` passes through a 2-flop synchronizer followed by a previous-value register. All three flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter `cnt` advances only on `i_baud_tick`.
- IDLE: waits for a falling edge (previous value 1, current value 0). Edge detection runs every clock, not only on ticks. On the edge: `cnt` <= 0, go to START.
  - A line that is held low never re-triggers. The line must return high, then fall again.
- START: on the tick where `cnt` == 7 (mid-bit), sample the line.
  - Line high: false start, return to IDLE.
  - Line low: `cnt` <= 0, latch `i_parity_type`, clear the bit index, go to DATA.
- DATA: on the tick where `cnt` == 15, sample, shift into bit [index] LSB first, `cnt` <= 0.
  - After bit `data_length`-1, go to PARITY (or to STOP when parity is compiled out).
- PARITY: on the tick where `cnt` == 15, sample the parity bit, `cnt` <= 0, go to STOP.
  - Error when (XOR of data bits) ^ (parity bit) ^ (latched type) == 1.
- STOP: on the tick where `cnt` == 15, sample the stop bit; line low sets the frame error. Go to IDLE.
  - On the next clock: `o_valid` pulses, and `o_data`, `o_parity_err` and `o_frame_err` update together.
- `o_data` and the error flags hold their values until the next `o_valid`.
- `i_parity_type` changes mid-frame have no effect on the current frame.
- Reset mid-frame: the FSM returns to IDLE, the partial frame is discarded, and no `o_valid` is issued.

## Timing
- Reset values: `o_data` = 0; `o_valid`, `o_parity_err`, `o_frame_err` and `o_busy` = 0.
- Synchronizer latency: 2 clocks from `i_rxd` to the edge detector.
- Counting ticks from the first tick after the edge is detected:
  - start sampled on tick 8;
  - data bit k sampled on tick 8 + 16*(k+1);
  - parity sampled on tick 8 + 16*(`data_length`+1);
  - stop sampled on tick 8 + 16*(`data_length`+2) = 168 for 8 bits with parity, or 152 without.
- `o_valid` is high exactly one clock, the clock after the stop-sampling tick.
- `o_busy` rises the clock after edge detection and falls with the `o_valid` clock.
- Back-to-back frames: a falling edge detected in the clock after STOP starts a new frame with no gap required.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, a parity bit is expected after the data bits, and `o_parity_err` is computed as above.
- Not defined: PARITY is removed, DATA goes directly to STOP, and `o_parity_err` is tied to 0. `i_parity_type` is ignored.

## Test plan
All scenarios use `i_baud_tick` every 4 clocks, bit time = 64 clocks, `data_length` = 8, `UART_RX_PARITY_EN` defined.
- Even type, send 0xA5 with parity 0 and stop 1 -> one `o_valid`, `o_data` = 0xA5, `o_parity_err` = 0, `o_frame_err` = 0.
- Odd type, same frame (parity 0) -> `o_data` = 0xA5, `o_parity_err` = 1. Then odd type, 0x01 with parity 0 -> `o_parity_err` = 0.
- Even type, 0x3C with stop bit 0 and the line held low 20 bit times -> one `o_valid` with `o_frame_err` = 1, no further `o_valid` until the line rises and a new frame is sent.
- Line low for 6 ticks then high -> no `o_valid`, `o_busy` returns to 0, and the next frame 0x5A is received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap -> two `o_valid` pulses 11 bit times apart, with data 0x00 then 0xFF and no errors.
- Assert `i_sys_rst_n` = 0 during bit 4 of a frame -> all outputs 0 the next clock, no `o_valid`, and the following clean frame 0x81 is received correctly.
